// File: rtl/axis_reg_slice_pkg.sv
// Shared types for the AXI4-Stream register slice: slice modes, skid FSM states,
// and the width of the packed {tdata,tstrb,tkeep,tlast,tid,tdest,tuser} word.
package axis_pkg;

    typedef enum logic [1:0] {
        AXIS_BYPASS = 2'd0,
        AXIS_FWD    = 2'd1,
        AXIS_FULL   = 2'd2
    } axis_slice_mode_e;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } skid_state_e;

    function automatic int axis_payload_width(input int dwidth, input int id_width,
                                              input int dest_width, input int user_width);
        return dwidth + 2 * (dwidth / 8) + 1 + id_width + dest_width + user_width;
    endfunction

endpackage

// File: rtl/axis_reg_slice_if.sv
// AXI4-Stream bundle; master drives tvalid and payload, slave drives tready.
// No clock inside: the owning block supplies aclk/areset as plain ports.
interface axistream_if #(
    parameter int DWIDTH     = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 6
);
    logic                    tvalid;
    logic                    tready;
    logic [DWIDTH-1:0]       tdata;
    logic [DWIDTH/8-1:0]     tstrb;
    logic [DWIDTH/8-1:0]     tkeep;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_reg_slice_stage.sv
// One slice stage on a flat valid/ready/payload link; latency 0 (bypass) or 1 cycle.
// Backpressure: bypass/forward pass m_rdy back combinationally, full mode uses a registered s_rdy and a skid.
module axis_reg_slice_stage
    import axis_pkg::*;
#(
    parameter int               PW   = 52,
    parameter axis_slice_mode_e MODE = AXIS_FULL
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          s_vld,
    output logic          s_rdy,
    input  logic [PW-1:0] s_dat,
    output logic          m_vld,
    input  logic          m_rdy,
    output logic [PW-1:0] m_dat
);

    if (MODE == AXIS_BYPASS) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = aclk ^ areset;
        assign m_vld = s_vld;
        assign m_dat = s_dat;
        assign s_rdy = m_rdy;
    end else if (MODE == AXIS_FWD) begin : g_fwd
        logic          vld_q, vld_d;
        logic          rdy_en_q, rdy_en_d;
        logic [PW-1:0] dat_q, dat_d;
        logic          load;

        // rdy_en_q holds upstream off during reset and for the cycle it is released
        assign s_rdy = rdy_en_q && (!vld_q || m_rdy);
        assign load  = s_vld && s_rdy;

        always_comb begin
            vld_d    = vld_q;
            dat_d    = dat_q;
            rdy_en_d = 1'b1;
            if (load) begin
                vld_d = 1'b1;
                dat_d = s_dat;
            end else if (m_rdy) begin
                vld_d = 1'b0;
            end
        end

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                vld_q    <= 1'b0;
                dat_q    <= '0;
                rdy_en_q <= 1'b0;
            end else begin
                vld_q    <= vld_d;
                dat_q    <= dat_d;
                rdy_en_q <= rdy_en_d;
            end
        end

        assign m_vld = vld_q;
        assign m_dat = dat_q;
    end else begin : g_full
        skid_state_e   state_q, state_d;
        logic [PW-1:0] main_q, main_d;
        logic [PW-1:0] skid_q, skid_d;
        logic          s_rdy_q, s_rdy_d;
        logic          m_vld_q, m_vld_d;
        logic          in_beat, out_beat;

        assign in_beat  = s_vld && s_rdy_q;
        assign out_beat = m_vld_q && m_rdy;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                S_EMPTY: begin
                    if (in_beat) begin
                        main_d  = s_dat;
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (in_beat && out_beat) begin
                        main_d = s_dat;
                    end else if (in_beat) begin
                        skid_d  = s_dat;
                        state_d = S_FULL;
                    end else if (out_beat) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_beat) begin
                        main_d  = skid_q;
                        state_d = S_BUSY;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
            // Handshake outputs are registered from the next state, so m_rdy never reaches s_rdy combinationally
            s_rdy_d = (state_d != S_FULL);
            m_vld_d = (state_d != S_EMPTY);
        end

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                state_q <= S_EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
                s_rdy_q <= 1'b0;
                m_vld_q <= 1'b0;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
                s_rdy_q <= s_rdy_d;
                m_vld_q <= m_vld_d;
            end
        end

        assign s_rdy = s_rdy_q;
        assign m_vld = m_vld_q;
        assign m_dat = main_q;
    end

endmodule

// File: rtl/axis_reg_slice.sv
// AXI4-Stream register slice: NUM_STAGES cascaded stages, latency NUM_STAGES cycles (0 in bypass).
// Backpressure: stalls upstream once all stages are full (1 beat/stage forward, 2 beats/stage full).
module axis_reg_slice
    import axis_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 6,
    parameter int NUM_STAGES = 1,
    parameter int MODE       = 2
) (
    input  logic         aclk,
    input  logic         areset,
    axistream_if.slave   s_axis,
    axistream_if.master  m_axis
);

    localparam int               PW         = axis_payload_width(DWIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);
    localparam axis_slice_mode_e SLICE_MODE = axis_slice_mode_e'(MODE);

    logic [PW-1:0] s_pay;
    logic [PW-1:0] m_pay;

    assign s_pay = {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast,
                    s_axis.tid, s_axis.tdest, s_axis.tuser};

    // Each stage owns its input-side link; neighbours are reached by hierarchical name
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        logic          in_vld, in_rdy, out_vld, out_rdy;
        logic [PW-1:0] in_dat, out_dat;

        if (i == 0) begin : g_head
            assign in_vld        = s_axis.tvalid;
            assign in_dat        = s_pay;
            assign s_axis.tready = in_rdy;
        end else begin : g_link
            assign in_vld = g_stage[i-1].out_vld;
            assign in_dat = g_stage[i-1].out_dat;
        end

        if (i == NUM_STAGES - 1) begin : g_tail
            assign out_rdy = m_axis.tready;
        end else begin : g_back
            assign out_rdy = g_stage[i+1].in_rdy;
        end

        axis_reg_slice_stage #(
            .PW   (PW),
            .MODE (SLICE_MODE)
        ) u_stage (
            .aclk   (aclk),
            .areset (areset),
            .s_vld  (in_vld),
            .s_rdy  (in_rdy),
            .s_dat  (in_dat),
            .m_vld  (out_vld),
            .m_rdy  (out_rdy),
            .m_dat  (out_dat)
        );
    end

    assign m_axis.tvalid = g_stage[NUM_STAGES-1].out_vld;
    assign m_pay         = g_stage[NUM_STAGES-1].out_dat;
    assign {m_axis.tdata, m_axis.tstrb, m_axis.tkeep, m_axis.tlast,
            m_axis.tid, m_axis.tdest, m_axis.tuser} = m_pay;

endmodule

// File: tb/tb_axis_reg_slice.sv
// Bench for axis_reg_slice: bypass (dut0), 3-stage forward (dut1) and 1-stage full-skid (dut2)
// instances, driven from directed sequences plus a randomized queue scoreboard.
module tb_axis_reg_slice;

    typedef struct packed {
        logic [31:0] tdata;
        logic [3:0]  tstrb;
        logic [3:0]  tkeep;
        logic        tlast;
        logic [3:0]  tid;
        logic [0:0]  tdest;
        logic [5:0]  tuser;
    } beat_t;

    typedef struct {
        logic  vld;
        beat_t beat;
        logic  rdy;
        logic  exp_mvld;
        beat_t exp_mbeat;
        logic  exp_srdy;
    } vec_t;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    axistream_if #(.DWIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(1), .USER_WIDTH(6))
        s0_if(), m0_if(), s1_if(), m1_if(), s2_if(), m2_if();

    logic  s0_vld, s1_vld, s2_vld, m0_rdy, m1_rdy, m2_rdy;
    logic  s0_rdy, s1_rdy, s2_rdy, m0_vld, m1_vld, m2_vld;
    beat_t s0_beat, s1_beat, s2_beat, m0_beat, m1_beat, m2_beat;

    assign s0_if.tvalid = s0_vld;
    assign s1_if.tvalid = s1_vld;
    assign s2_if.tvalid = s2_vld;
    assign {s0_if.tdata, s0_if.tstrb, s0_if.tkeep, s0_if.tlast, s0_if.tid, s0_if.tdest, s0_if.tuser} = s0_beat;
    assign {s1_if.tdata, s1_if.tstrb, s1_if.tkeep, s1_if.tlast, s1_if.tid, s1_if.tdest, s1_if.tuser} = s1_beat;
    assign {s2_if.tdata, s2_if.tstrb, s2_if.tkeep, s2_if.tlast, s2_if.tid, s2_if.tdest, s2_if.tuser} = s2_beat;
    assign s0_rdy = s0_if.tready;
    assign s1_rdy = s1_if.tready;
    assign s2_rdy = s2_if.tready;
    assign m0_if.tready = m0_rdy;
    assign m1_if.tready = m1_rdy;
    assign m2_if.tready = m2_rdy;
    assign m0_vld = m0_if.tvalid;
    assign m1_vld = m1_if.tvalid;
    assign m2_vld = m2_if.tvalid;
    assign m0_beat = {m0_if.tdata, m0_if.tstrb, m0_if.tkeep, m0_if.tlast, m0_if.tid, m0_if.tdest, m0_if.tuser};
    assign m1_beat = {m1_if.tdata, m1_if.tstrb, m1_if.tkeep, m1_if.tlast, m1_if.tid, m1_if.tdest, m1_if.tuser};
    assign m2_beat = {m2_if.tdata, m2_if.tstrb, m2_if.tkeep, m2_if.tlast, m2_if.tid, m2_if.tdest, m2_if.tuser};

    axis_reg_slice #(.DWIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(1), .USER_WIDTH(6), .NUM_STAGES(1), .MODE(0))
        dut0 (.aclk(aclk), .areset(areset), .s_axis(s0_if), .m_axis(m0_if));
    axis_reg_slice #(.DWIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(1), .USER_WIDTH(6), .NUM_STAGES(3), .MODE(1))
        dut1 (.aclk(aclk), .areset(areset), .s_axis(s1_if), .m_axis(m1_if));
    axis_reg_slice #(.DWIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(1), .USER_WIDTH(6), .NUM_STAGES(1), .MODE(2))
        dut2 (.aclk(aclk), .areset(areset), .s_axis(s2_if), .m_axis(m2_if));

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %b required %b", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input beat_t act, input beat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Every field derived from n so corruption or duplication of any field is visible
    function automatic beat_t inc_beat(input int n);
        beat_t b;
        b.tdata = 32'hA500_0000 + 32'(n);
        b.tstrb = n[3:0];
        b.tkeep = ~n[3:0];
        b.tlast = (n % 8 == 7);
        b.tid   = n[4:1];
        b.tdest = n[0:0];
        b.tuser = n[5:0];
        return b;
    endfunction

    function automatic beat_t rnd_beat(input int n);
        beat_t b;
        b.tdata = $urandom;
        b.tstrb = 4'($urandom);
        b.tkeep = 4'($urandom);
        b.tlast = (n % 8 == 7);
        b.tid   = 4'($urandom);
        b.tdest = 1'($urandom);
        b.tuser = 6'($urandom);
        return b;
    endfunction

    vec_t vt[8];

    task automatic apply_table(input string tag);
        for (int i = 0; i < 8; i++) begin
            s0_vld  = vt[i].vld;
            s0_beat = vt[i].beat;
            m0_rdy  = vt[i].rdy;
            #1;
            chkb({tag, "_mvld"}, m0_vld, vt[i].exp_mvld);
            chkd({tag, "_mbeat"}, m0_beat, vt[i].exp_mbeat);
            chkb({tag, "_srdy"}, s0_rdy, vt[i].exp_srdy);
        end
    endtask

    beat_t q1[$], q2[$];

    initial begin
        int    lat;
        int    sent1, sent2, got1, got2;
        logic  a_in1, a_in2, hold1, hold2;
        beat_t prev1, prev2;
        localparam int N1 = 1000;
        localparam int N2 = 300;

        // Bypass is a direct connect: each output mirrors its input in the same cycle
        for (int i = 0; i < 8; i++) begin
            vt[i].vld       = (i % 2 == 1);
            vt[i].rdy       = ((i / 2) % 2 == 1);
            vt[i].beat      = rnd_beat(i);
            vt[i].exp_mvld  = (i % 2 == 1);
            vt[i].exp_srdy  = ((i / 2) % 2 == 1);
            vt[i].exp_mbeat = vt[i].beat;
        end

        s0_vld = 0; s1_vld = 0; s2_vld = 0;
        s0_beat = '0; s1_beat = '0; s2_beat = '0;
        m0_rdy = 0; m1_rdy = 1; m2_rdy = 1;

        repeat (2) @(negedge aclk);
        #1;
        chkb("rst_m2_vld", m2_vld, 1'b0);
        chkd("rst_m2_dat", m2_beat, '0);
        chkb("rst_s2_rdy", s2_rdy, 1'b0);
        chkb("rst_m1_vld", m1_vld, 1'b0);
        chkd("rst_m1_dat", m1_beat, '0);
        chkb("rst_s1_rdy", s1_rdy, 1'b0);
        apply_table("byp_in_rst");

        @(negedge aclk);
        areset = 0;
        #1;
        chkb("rel_s2_rdy_pre", s2_rdy, 1'b0);
        chkb("rel_s1_rdy_pre", s1_rdy, 1'b0);
        @(posedge aclk);
        #1;
        chkb("rel_s2_rdy_edge", s2_rdy, 1'b1);
        chkb("rel_s1_rdy_edge", s1_rdy, 1'b1);
        apply_table("byp_run");

        // Three forward stages: one beat surfaces after three edges
        @(negedge aclk);
        s1_vld = 1; s1_beat = inc_beat(100); m1_rdy = 1;
        lat = 0;
        do begin
            @(negedge aclk);
            s1_vld = 0;
            #1;
            lat++;
        end while (!m1_vld && lat < 8);
        chki("fwd_latency", lat, 3);
        chkd("fwd_lat_dat", m1_beat, inc_beat(100));
        @(negedge aclk);
        #1;
        chkb("fwd_lat_drained", m1_vld, 1'b0);

        // Full mode, continuous ready: 16 beats, one cycle latency, no bubbles
        m2_rdy = 1;
        for (int i = 0; i <= 17; i++) begin
            @(negedge aclk);
            if (i < 16) begin
                s2_vld = 1; s2_beat = inc_beat(i);
            end else begin
                s2_vld = 0;
            end
            #1;
            if (i < 16) chkb("b2b_srdy", s2_rdy, 1'b1);
            if (i == 0 || i == 17) begin
                chkb("b2b_idle", m2_vld, 1'b0);
            end else begin
                chkb("b2b_vld", m2_vld, 1'b1);
                chkd("b2b_dat", m2_beat, inc_beat(i - 1));
            end
        end

        // Full mode, downstream stalled: two beats absorbed, third held off
        m2_rdy = 0;
        @(negedge aclk); s2_vld = 1; s2_beat = inc_beat(20); #1;
        chkb("bp_rdy_a", s2_rdy, 1'b1);
        @(negedge aclk); s2_beat = inc_beat(21); #1;
        chkb("bp_rdy_b", s2_rdy, 1'b1);
        chkd("bp_head_a0", m2_beat, inc_beat(20));
        @(negedge aclk); s2_beat = inc_beat(22); #1;
        chkb("bp_stall", s2_rdy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk); #1;
            chkb("bp_hold_rdy", s2_rdy, 1'b0);
            chkb("bp_hold_vld", m2_vld, 1'b1);
            chkd("bp_hold_a", m2_beat, inc_beat(20));
        end
        @(negedge aclk); m2_rdy = 1; #1;
        chkd("bp_out_a", m2_beat, inc_beat(20));
        @(negedge aclk); #1;
        chkd("bp_out_b", m2_beat, inc_beat(21));
        chkb("bp_rdy_back", s2_rdy, 1'b1);
        @(negedge aclk); s2_vld = 0; #1;
        chkb("bp_vld_c", m2_vld, 1'b1);
        chkd("bp_out_c", m2_beat, inc_beat(22));
        @(negedge aclk); #1;
        chkb("bp_empty", m2_vld, 1'b0);

        // Reset with two beats buffered: outputs drop without waiting for a clock
        m2_rdy = 0;
        @(negedge aclk); s2_vld = 1; s2_beat = inc_beat(30);
        @(negedge aclk); s2_beat = inc_beat(31);
        @(negedge aclk); s2_vld = 0; #1;
        chkb("rst_pre_vld", m2_vld, 1'b1);
        chkb("rst_pre_full", s2_rdy, 1'b0);
        #2;
        areset = 1;
        #1;
        chkb("rst_async_vld", m2_vld, 1'b0);
        chkd("rst_async_dat", m2_beat, '0);
        chkb("rst_async_rdy", s2_rdy, 1'b0);
        @(negedge aclk);
        areset = 0; m2_rdy = 1;
        #1;
        chkb("rst2_rdy_pre", s2_rdy, 1'b0);
        @(posedge aclk); #1;
        chkb("rst2_rdy_edge", s2_rdy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk); #1;
            chkb("rst_no_old", m2_vld, 1'b0);
        end

        // Randomized traffic: dut1 random valid/ready, dut2 random valid with ready toggling 1010
        sent1 = 0; sent2 = 0; got1 = 0; got2 = 0;
        a_in1 = 0; a_in2 = 0; hold1 = 0; hold2 = 0;
        prev1 = '0; prev2 = '0;
        s1_vld = 0; s2_vld = 0;
        for (int cyc = 0; cyc < 20000 && (got1 < N1 || got2 < N2); cyc++) begin
            @(negedge aclk);
            if (a_in1) s1_vld = 0;
            if (!s1_vld && sent1 < N1 && $urandom_range(1, 0) == 1) begin
                s1_vld = 1; s1_beat = rnd_beat(sent1); sent1++;
            end
            m1_rdy = ($urandom_range(1, 0) == 1);
            if (a_in2) s2_vld = 0;
            if (!s2_vld && sent2 < N2 && $urandom_range(3, 0) != 0) begin
                s2_vld = 1; s2_beat = inc_beat(sent2); sent2++;
            end
            m2_rdy = (cyc % 2 == 0);
            #1;

            if (hold1) begin
                chkb("fwd_hold_vld", m1_vld, 1'b1);
                chkd("fwd_hold_dat", m1_beat, prev1);
            end
            if (m1_vld && m1_rdy) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fwd_spurious: actual beat %h required none", m1_beat);
                end else begin
                    chkd("fwd_beat", m1_beat, q1.pop_front());
                    got1++;
                end
            end
            a_in1 = s1_vld && s1_rdy;
            if (a_in1) q1.push_back(s1_beat);
            chkb("fwd_capacity", q1.size() <= 3, 1'b1);
            hold1 = m1_vld && !m1_rdy;
            prev1 = m1_beat;

            if (hold2) begin
                chkb("full_hold_vld", m2_vld, 1'b1);
                chkd("full_hold_dat", m2_beat, prev2);
            end
            if (m2_vld && m2_rdy) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL full_spurious: actual beat %h required none", m2_beat);
                end else begin
                    chkd("full_beat", m2_beat, q2.pop_front());
                    got2++;
                end
            end
            a_in2 = s2_vld && s2_rdy;
            if (a_in2) q2.push_back(s2_beat);
            chkb("full_capacity", q2.size() <= 2, 1'b1);
            hold2 = m2_vld && !m2_rdy;
            prev2 = m2_beat;
        end
        chki("fwd_delivered", got1, N1);
        chki("full_delivered", got2, N2);
        chki("fwd_left", q1.size(), 0);
        chki("full_left", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
